// File: rtl/prio_arb_enc.sv
// Registered N-way priority encoder / arbiter with fixed-priority or round-robin
// selection, presenting a sticky grant that is released by a valid/ack handshake.
//
// Handshake: a grant is offered while gnt_valid = 1 and completes on the edge where
// gnt_ack = 1; gnt_ack is ignored while gnt_valid = 0. The grant is held unchanged
// until that completing edge.
module prio_arb_enc #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            mode,
    input  logic            gnt_ack,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic [N-1:0]    gnt_onehot,
    output logic [IDXW-1:0] ptr
);

    localparam logic            S_IDLE  = 1'b0;
    localparam logic            S_GRANT = 1'b1;
    localparam logic [IDXW-1:0] PTR_RST = IDXW'(N - 1);
    localparam logic [N-1:0]    ONE     = {{(N-1){1'b0}}, 1'b1};

    logic            state;
    logic [IDXW-1:0] ptr_next;
    logic [IDXW-1:0] arb_ptr;
    logic [IDXW-1:0] win;
    logic [N-1:0]    win_onehot;

    // Scan candidates in priority order; the first requesting index wins.
    function automatic logic [IDXW-1:0] arbitrate(
        input logic [N-1:0]    r,
        input logic [IDXW-1:0] p,
        input logic            m
    );
        logic [IDXW-1:0] sel;
        logic [IDXW-1:0] cand;
        logic            found;
        int              j;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (m) begin
                j = int'(p) - k;
                if (j < 0) j = j + N;
            end else begin
                j = N - 1 - k;
            end
            cand = IDXW'(j);
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // In GRANT the only arbitration instant is the ack cycle, which uses the
    // pointer as it will be after this grant is served.
    always_comb begin
        ptr_next = ptr;
        if (mode) begin
            ptr_next = (gnt_idx == '0) ? PTR_RST : gnt_idx - IDXW'(1);
        end
        arb_ptr    = (state == S_GRANT) ? ptr_next : ptr;
        win        = arbitrate(req, arb_ptr, mode);
        win_onehot = ONE << win;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            ptr        <= PTR_RST;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req != '0) begin
                        state      <= S_GRANT;
                        gnt_valid  <= 1'b1;
                        gnt_idx    <= win;
                        gnt_onehot <= win_onehot;
                    end else begin
                        gnt_valid  <= 1'b0;
                        gnt_onehot <= '0;
                    end
                end
                S_GRANT: begin
                    if (gnt_ack) begin
                        ptr <= ptr_next;
                        if (req != '0) begin
                            gnt_idx    <= win;
                            gnt_onehot <= win_onehot;
                        end else begin
                            state      <= S_IDLE;
                            gnt_valid  <= 1'b0;
                            gnt_onehot <= '0;
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    gnt_valid  <= 1'b0;
                    gnt_onehot <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_arb_enc.sv
// Bench for prio_arb_enc: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a priority-list model of the arbiter.
module tb_prio_arb_enc;

    localparam int N    = 8;
    localparam int IDXW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic            mode = 1'b0;
    logic            gnt_ack = 1'b0;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic [N-1:0]    gnt_onehot;
    logic [IDXW-1:0] ptr;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    // model state
    bit m_valid;
    int m_idx;
    int m_ptr;

    logic [IDXW-1:0] exp_q[$];

    prio_arb_enc #(.N(N), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .req(req), .mode(mode), .gnt_ack(gnt_ack),
        .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot), .ptr(ptr)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // priority order as an explicit list; the first requester in the list wins
    function automatic int pick(input logic [N-1:0] r, input int p, input bit m);
        int order[$];
        if (!m) begin
            for (int i = N - 1; i >= 0; i--) order.push_back(i);
        end else begin
            for (int k = 0; k < N; k++) order.push_back((p - k + N) % N);
        end
        foreach (order[i]) if (r[order[i]]) return order[i];
        return -1;
    endfunction

    always @(posedge clk) begin
        int p;
        if (rst) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = N - 1;
        end else if (!m_valid) begin
            if (req != '0) begin
                m_idx   = pick(req, m_ptr, mode);
                m_valid = 1'b1;
            end
        end else if (gnt_ack) begin
            p = m_ptr;
            if (mode) p = (m_idx == 0) ? N - 1 : m_idx - 1;
            m_ptr = p;
            if (req != '0) m_idx = pick(req, p, mode);
            else m_valid = 1'b0;
        end
    end

    // compare process: outputs against the model every cycle once reset has been seen
    always @(negedge clk) begin
        logic [N-1:0] m_onehot;
        if (started) begin
            m_onehot = m_valid ? (N'(1) << m_idx) : '0;
            check("valid", 64'(gnt_valid), 64'(m_valid));
            check("idx",   64'(gnt_idx),   64'(m_idx));
            check("onehot",64'(gnt_onehot),64'(m_onehot));
            check("ptr",   64'(ptr),       64'(m_ptr));
        end
    end

    // driver: apply inputs just after an edge, consume them on the next edge
    task automatic cyc(input logic [N-1:0] r, input logic m, input logic a);
        req = r; mode = m; gnt_ack = a;
        @(posedge clk); #1;
    endtask

    task automatic expect_grant(input string name, input logic v, input int idx, input int p);
        check({name, "_valid"}, 64'(gnt_valid), 64'(v));
        check({name, "_idx"},   64'(gnt_idx),   64'(idx));
        check({name, "_onehot"},64'(gnt_onehot),v ? 64'(N'(1) << idx) : 64'(0));
        check({name, "_ptr"},   64'(ptr),       64'(p));
        check({name, "_model"}, 64'(m_idx),     64'(idx));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        if ($bits(gnt_idx) != $clog2(N)) begin
            $display("FAIL idxw actual=%0d required=%0d", $bits(gnt_idx), $clog2(N));
            $fatal(1, "index width");
        end
        @(posedge clk); #1;
        do_reset(2);
        started = 1'b1;

        // reset / idle
        for (int i = 0; i < 10; i++) begin
            cyc('0, 1'b0, 1'b0);
            expect_grant("idle", 1'b0, 0, 7);
        end

        // fixed priority, sticky while ack low
        cyc(8'b0010_0110, 1'b0, 1'b0);
        expect_grant("fix_first", 1'b1, 5, 7);
        for (int i = 0; i < 5; i++) begin
            cyc(8'b1000_0000, 1'b0, 1'b0);
            expect_grant("fix_hold", 1'b1, 5, 7);
        end
        cyc(8'b1000_0000, 1'b0, 1'b1);
        expect_grant("fix_next", 1'b1, 7, 7);
        cyc('0, 1'b0, 1'b1);
        expect_grant("fix_drain", 1'b0, 7, 7);

        // round-robin fairness with continuous requests and ack
        cyc(8'hFF, 1'b1, 1'b1);
        expect_grant("rr_first", 1'b1, 7, 7);
        for (int g = 6; g >= 0; g--) exp_q.push_back(IDXW'(g));
        exp_q.push_back(IDXW'(7));
        while (exp_q.size() > 0) begin
            logic [IDXW-1:0] e;
            e = exp_q.pop_front();
            cyc(8'hFF, 1'b1, 1'b1);
            expect_grant("rr_fair", 1'b1, int'(e), int'(e));
        end
        cyc('0, 1'b1, 1'b1);
        expect_grant("rr_drain", 1'b0, 7, 6);

        // round-robin skip and wrap
        cyc(8'b0000_0101, 1'b1, 1'b1);
        expect_grant("rr_skip0", 1'b1, 2, 6);
        cyc(8'b0000_0101, 1'b1, 1'b1);
        expect_grant("rr_skip1", 1'b1, 0, 1);
        cyc(8'b0000_0101, 1'b1, 1'b1);
        expect_grant("rr_wrap", 1'b1, 2, 7);
        cyc(8'b0000_0101, 1'b1, 1'b1);
        expect_grant("rr_skip3", 1'b1, 0, 1);
        cyc('0, 1'b1, 1'b1);
        expect_grant("rr_wrap_ptr", 1'b0, 0, 7);

        // sticky grant while winner drops its request
        cyc(8'b0000_1000, 1'b0, 1'b0);
        expect_grant("drop_first", 1'b1, 3, 7);
        for (int i = 0; i < 3; i++) begin
            cyc('0, 1'b0, 1'b0);
            expect_grant("drop_hold", 1'b1, 3, 7);
        end
        cyc('0, 1'b0, 1'b1);
        expect_grant("drop_ack", 1'b0, 3, 7);

        // reset in the middle of a grant with ptr = 2
        cyc(8'b0000_1000, 1'b1, 1'b0);
        cyc(8'b0000_1000, 1'b1, 1'b1);
        expect_grant("mid_setup", 1'b1, 3, 2);
        rst = 1'b1;
        cyc(8'b0000_1000, 1'b1, 1'b0);
        rst = 1'b0;
        expect_grant("mid_rst", 1'b0, 0, 7);
        cyc(8'h11, 1'b1, 1'b0);
        expect_grant("mid_after", 1'b1, 4, 7);

        // random traffic, model-checked every cycle
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] r;
            r = N'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) r = '0;
            rst = ($urandom_range(0, 49) == 0);
            cyc(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
        end
        rst = 1'b0;
        cyc('0, 1'b0, 1'b1);
        @(negedge clk);
        started = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prio_arb_enc.md
# prio_arb_enc

Parametrised, registered successor to the team's 3-bit combinational priority encoder. It takes N request lines and selects one winner, either by fixed priority (highest index wins) or by round-robin. The winner is presented as a held grant with a valid/ack handshake. It sits between request-producing blocks and a shared resource, and replaces ad-hoc combinational encoders wherever the requester count exceeds 3 or fairness is needed.

## Interface
- N, default 8: number of request lines; 2 ≤ N ≤ 64.
- IDXW, default 3: index width; must equal ceil(log2(N)) and is checked by the bench.
- clk  input  1  rising-edge clock; only clock.
- rst  input  1  reset, synchronous and active-high.
- req  input  N  request vector; bit i = requester i.
- mode  input  1  0 = fixed priority (highest set index wins); 1 = round-robin.
- gnt_ack  input  1  consumer accepts current grant; ignored while gnt_valid = 0.
- gnt_valid  output  1  grant registers hold a valid winner.
- gnt_idx  output  IDXW  binary index of winner.
- gnt_onehot  output  N  one-hot winner; all-zero when gnt_valid = 0.
- ptr  output  IDXW  current round-robin start pointer (debug/observability).

## Operation
- Two states: IDLE and GRANT. All outputs are registered.
- Reset (rst = 1 at a clock edge) sets the following, overriding all other inputs that cycle:
  - state = IDLE, gnt_valid = 0, gnt_idx = 0, gnt_onehot = 0, ptr = N-1.
- Arbitration function, evaluated on a request vector R with start pointer P:
  - Fixed mode: winner = highest i with R[i] = 1. P is ignored.
  - Round-robin mode: search i = P, P-1, …, 0, N-1, …, P+1 (descending, wrapping). The first set bit wins.
- IDLE:
  - If req ≠ 0, arbitrate with the current ptr, load gnt_idx and gnt_onehot, set gnt_valid = 1, and go to GRANT.
  - Otherwise stay in IDLE with outputs cleared.
- GRANT:
  - The grant is sticky. gnt_idx and gnt_onehot are held while gnt_ack = 0, even if the winner drops req or higher-priority requests arrive.
  - On gnt_ack = 1, the handshake completes:
    - Round-robin mode: ptr_next = (gnt_idx == 0) ? N-1 : gnt_idx-1, so the just-served requester becomes lowest priority. Fixed mode: ptr is unchanged.
    - If req ≠ 0 in the ack cycle, arbitrate with ptr_next and stay in GRANT with the new winner. This gives back-to-back grants with no bubble, and the served requester may win again if it is the only one asserting.
    - If req = 0, go to IDLE and clear gnt_valid and gnt_onehot. gnt_idx keeps its last value.
- mode is sampled only at arbitration instants (IDLE with req ≠ 0, or the ack cycle). Changing mode mid-grant does not disturb the held grant.
- ptr updates only on an acked grant made in round-robin mode.
- Invariant: gnt_onehot == (gnt_valid ? 1 << gnt_idx : 0).

## Timing
- Latency: req asserted at edge k (sampled in IDLE) gives gnt_valid = 1 after edge k.
- Throughput: one grant per cycle when gnt_ack is held high and requests are continuous.
- Ack to next grant: the new winner is visible after the same edge that consumes the ack.
- Ack to IDLE: gnt_valid falls after the ack edge when req = 0.
- Reset mid-grant: the grant is dropped in one cycle, ptr returns to N-1, and no ack is needed.
- Pointer wrap: served index 0 makes ptr = N-1.

## Test plan
- Reset/idle: with rst high for 2 cycles, then req = 0, all outputs hold at 0 and ptr = 7 for 10 cycles.
- Fixed priority: mode = 0, req = 8'b0010_0110.
  - Expected: grant idx 5, onehot 8'b0010_0000 one cycle later.
  - Hold ack = 0 for 5 cycles while req changes to 8'b1000_0000: grant stays 5.
  - Ack once: the next grant is idx 7.
- Round-robin fairness: mode = 1, req = 8'hFF constant, gnt_ack = 1.
  - Expected grants: 7, 6, 5, …, 0, 7 on consecutive cycles.
  - ptr goes 6, 5, …, 0, 7.
- Round-robin skip/wrap: mode = 1, req = 8'b0000_0101, ack every cycle.
  - Expected grants alternate 2, 0, 2, 0.
  - ptr after granting 0 is 7.
- Sticky grant with drop: the winner at idx 3 deasserts req before ack.
  - Expected: grant is still held until ack.
  - On ack with req = 0, gnt_valid drops next cycle and onehot = 0.
- Reset mid-grant: assert rst during GRANT with ptr = 2.
  - Expected next cycle: gnt_valid = 0, ptr = 7.
  - With req = 8'h11 and mode = 1, the first grant after reset is idx 4.
